// File: rtl/lut_interp_ram.sv
// Streaming multi-table LUT with linear interpolation between entries idx and idx+1.
// Optional macro LUT_INTERP_ROUND_EN selects round-half-up instead of floor in the final stage.
module lut_interp_ram #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 9,
    parameter int FWIDTH     = 7,
    parameter int NUM_TABLES = 2,
    parameter int WRAP       = 0,
    localparam int TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [TW-1:0]             wr_table,
    input  logic [AWIDTH-1:0]         wr_addr,
    input  logic [DWIDTH-1:0]         wr_data,
    input  logic [AWIDTH+FWIDTH-1:0]  i_tdata,
    input  logic [TW-1:0]             i_tuser,
    input  logic                      i_tlast,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [DWIDTH-1:0]         o_tdata,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready
);

    localparam int DEPTH = 2 ** (TW + AWIDTH);
    localparam int PW    = DWIDTH + FWIDTH + 2;
    localparam logic [AWIDTH-1:0] IDX_MAX = '1;

    // Handshake: a beat moves on a port when valid & ready are both high at a
    // rising clk edge. The whole pipeline advances together on en; ready never
    // depends on the upstream valid, and o_tvalid/o_tdata/o_tlast hold while
    // o_tvalid & ~o_tready.
    logic en;
    assign en       = ~o_tvalid | o_tready;
    assign i_tready = en;

    // Table storage: write port lands every wr_en cycle, reads are read-first.
    logic signed [DWIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[{wr_table, wr_addr}] <= wr_data;
        end
    end

    // Stage 1: capture sample and precompute the neighbour address.
    logic [AWIDTH-1:0] in_idx;
    logic [AWIDTH-1:0] nidx_w;

    always_comb begin
        in_idx = i_tdata[AWIDTH+FWIDTH-1:FWIDTH];
        nidx_w = in_idx + AWIDTH'(1);
        if (in_idx == IDX_MAX) begin
            nidx_w = (WRAP != 0) ? '0 : in_idx;
        end
    end

    logic              s1_v;
    logic [TW-1:0]     s1_t;
    logic [AWIDTH-1:0] s1_idx;
    logic [AWIDTH-1:0] s1_nidx;
    logic [FWIDTH-1:0] s1_frac;
    logic              s1_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
        end else if (en) begin
            s1_v    <= i_tvalid;
            s1_t    <= i_tuser;
            s1_idx  <= in_idx;
            s1_nidx <= nidx_w;
            s1_frac <= i_tdata[FWIDTH-1:0];
            s1_last <= i_tlast;
        end
    end

    // Stage 2: registered dual read of both neighbouring entries.
    logic                     s2_v;
    logic signed [DWIDTH-1:0] s2_a;
    logic signed [DWIDTH-1:0] s2_b;
    logic [FWIDTH-1:0]        s2_frac;
    logic                     s2_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v <= 1'b0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_a    <= ram[{s1_t, s1_idx}];
            s2_b    <= ram[{s1_t, s1_nidx}];
            s2_frac <= s1_frac;
            s2_last <= s1_last;
        end
    end

    // Stage 3a: slope b-a, one bit wider so it cannot overflow.
    logic signed [DWIDTH:0] diff_w;
    assign diff_w = {s2_b[DWIDTH-1], s2_b} - {s2_a[DWIDTH-1], s2_a};

    logic                     s3_v;
    logic signed [DWIDTH-1:0] s3_a;
    logic signed [DWIDTH:0]   s3_diff;
    logic [FWIDTH-1:0]        s3_frac;
    logic                     s3_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_v <= 1'b0;
        end else if (en) begin
            s3_v    <= s2_v;
            s3_a    <= s2_a;
            s3_diff <= diff_w;
            s3_frac <= s2_frac;
            s3_last <= s2_last;
        end
    end

    // Stage 3b: slope times unsigned fraction, registered to keep the multiplier off the adder path.
    logic [PW-1:0]        diff_ext;
    logic [PW-1:0]        frac_ext;
    logic signed [PW-1:0] prod_w;

    always_comb begin
        diff_ext = {{(PW-DWIDTH-1){s3_diff[DWIDTH]}}, s3_diff};
        frac_ext = {{(PW-FWIDTH){1'b0}}, s3_frac};
        prod_w   = $signed(diff_ext) * $signed(frac_ext);
    end

    logic                     s4_v;
    logic signed [DWIDTH-1:0] s4_a;
    logic signed [PW-1:0]     s4_prod;
    logic                     s4_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            s4_v <= 1'b0;
        end else if (en) begin
            s4_v    <= s3_v;
            s4_a    <= s3_a;
            s4_prod <= prod_w;
            s4_last <= s3_last;
        end
    end

    // Final add: the result always lies between a and b, so the low DWIDTH bits are exact.
    logic signed [PW-1:0] adj_w;
    logic signed [PW-1:0] shift_w;
    logic signed [PW-1:0] sum_w;

    always_comb begin
`ifdef LUT_INTERP_ROUND_EN
        adj_w = s4_prod + (PW'(1) <<< (FWIDTH - 1));
`else
        adj_w = s4_prod;
`endif
        shift_w = adj_w >>> FWIDTH;
        sum_w   = $signed({{(PW-DWIDTH){s4_a[DWIDTH-1]}}, s4_a}) + shift_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else if (en) begin
            o_tvalid <= s4_v;
            o_tdata  <= sum_w[DWIDTH-1:0];
            o_tlast  <= s4_last;
        end
    end

endmodule

// File: tb/tb_lut_interp_ram.sv
// Directed bench for lut_interp_ram: vector table, streaming with backpressure,
// read/write collision and mid-stream reset.
module tb_lut_interp_ram;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int FW = 7;
    localparam int TW = 1;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic [TW-1:0]        wr_table;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [AW+FW-1:0]     i_tdata;
    logic [TW-1:0]        i_tuser;
    logic                 i_tlast;
    logic                 i_tvalid;
    logic                 i_tready;
    logic signed [DW-1:0] o_tdata;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready;

    lut_interp_ram #(
        .DWIDTH(DW), .AWIDTH(AW), .FWIDTH(FW), .NUM_TABLES(2), .WRAP(0)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_table(wr_table), .wr_addr(wr_addr), .wr_data(wr_data),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int   t;
        int   idx;
        int   frac;
        logic last;
        int   exp;
    } vec_t;

    vec_t vecs[10];

`ifdef LUT_INTERP_ROUND_EN
    localparam int E_T1_3_64  = 24;
    localparam int E_T0_0_64  = 4;
    localparam int E_T0_510   = 71;
`else
    localparam int E_T1_3_64  = 23;
    localparam int E_T0_0_64  = 3;
    localparam int E_T0_510   = 70;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int t, input int addr, input int data);
        wr_en    = 1'b1;
        wr_table = t[TW-1:0];
        wr_addr  = addr[AW-1:0];
        wr_data  = data[DW-1:0];
        tick();
        wr_en    = 1'b0;
    endtask

    // Drives one sample, optionally writes t1[3]=500 on the cycle its S2 read happens,
    // then measures latency and checks the result.
    task automatic send_one(input int t, input int idx, input int frac, input logic last,
                            input int exp, input logic collide, input string name);
        int cnt;
        i_tvalid = 1'b1;
        i_tuser  = t[TW-1:0];
        i_tdata  = {idx[AW-1:0], frac[FW-1:0]};
        i_tlast  = last;
        #1;
        chk({name, ".ready"}, {31'd0, i_tready}, 1);
        tick();
        i_tvalid = 1'b0;
        cnt = 0;
        if (collide) begin
            wr_en    = 1'b1;
            wr_table = 1'b1;
            wr_addr  = 9'd3;
            wr_data  = 16'd500;
            tick();
            wr_en    = 1'b0;
            cnt      = 1;
        end
        while (!o_tvalid && cnt < 12) begin
            tick();
            cnt++;
        end
        chk({name, ".latency"}, cnt, 4);
        chk({name, ".data"}, $signed(o_tdata), exp);
        chk({name, ".last"}, {31'd0, o_tlast}, {31'd0, last});
    endtask

    logic [DW:0] exp_q[$];
    int pat[4] = '{1, 0, 0, 1};

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_table = '0;
        wr_addr  = '0;
        wr_data  = '0;
        i_tdata  = '0;
        i_tuser  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (3) tick();
        chk("reset.o_tvalid", {31'd0, o_tvalid}, 0);
        chk("reset.o_tdata", $signed(o_tdata), 0);
        chk("reset.o_tlast", {31'd0, o_tlast}, 0);

        // tables load while reset is still asserted: writes must not depend on it
        for (int k = 0; k < 512; k++) wr(0, k, 16 * k);
        reset = 1'b0;
        tick();
        chk("post_reset.i_tready", {31'd0, i_tready}, 1);
        for (int k = 0; k < 512; k++) wr(1, k, 7 * k - 1);
        wr(0, 10, 100);
        wr(0, 11, -100);
        wr(0, 511, 7);
        wr(0, 0, -9);

        vecs[0] = '{t: 0, idx: 5,   frac: 64,  last: 1'b1, exp: 88};
        vecs[1] = '{t: 0, idx: 10,  frac: 1,   last: 1'b0, exp: 98};
        vecs[2] = '{t: 0, idx: 10,  frac: 96,  last: 1'b1, exp: -50};
        vecs[3] = '{t: 0, idx: 511, frac: 64,  last: 1'b0, exp: 7};
        vecs[4] = '{t: 0, idx: 511, frac: 127, last: 1'b1, exp: 7};
        vecs[5] = '{t: 0, idx: 5,   frac: 0,   last: 1'b0, exp: 80};
        vecs[6] = '{t: 1, idx: 3,   frac: 64,  last: 1'b1, exp: E_T1_3_64};
        vecs[7] = '{t: 0, idx: 0,   frac: 64,  last: 1'b0, exp: E_T0_0_64};
        vecs[8] = '{t: 0, idx: 510, frac: 127, last: 1'b1, exp: E_T0_510};
        vecs[9] = '{t: 1, idx: 511, frac: 100, last: 1'b0, exp: 3576};

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].t, vecs[i].idx, vecs[i].frac, vecs[i].last, vecs[i].exp,
                     1'b0, $sformatf("vec%0d", i));
        end
        tick();

        // streaming with o_tready pattern 1,0,0,1
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            logic [DW:0] e;
            while (got < 16 && cyc < 300) begin
                o_tready = pat[cyc % 4][0];
                if (sent < 16) begin
                    i_tvalid = 1'b1;
                    i_tuser  = 1'b0;
                    i_tdata  = {AW'(20 + sent), FW'(64)};
                    i_tlast  = (sent % 4 == 3);
                end else begin
                    i_tvalid = 1'b0;
                end
                #1;
                chk("stream.i_tready", {31'd0, i_tready}, {31'd0, !(o_tvalid && !o_tready)});
                if (i_tvalid && i_tready) begin
                    exp_q.push_back({(sent % 4 == 3), DW'(16 * (20 + sent) + 8)});
                    sent++;
                end
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("stream.unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("stream%0d.data", got), $signed(o_tdata), $signed(e[DW-1:0]));
                        chk($sformatf("stream%0d.last", got), {31'd0, o_tlast}, {31'd0, e[DW]});
                    end
                    got++;
                end
                tick();
                cyc++;
            end
            chk("stream.count", got, 16);
            i_tvalid = 1'b0;
            o_tready = 1'b1;
            tick();
        end

        // read/write collision on t1[3]
        send_one(1, 3, 0, 1'b0, 20, 1'b1, "collide.old");
        send_one(1, 3, 0, 1'b1, 500, 1'b0, "collide.new");
        send_one(0, 3, 0, 1'b0, 48, 1'b0, "collide.t0");

        // reset with three samples in flight
        begin
            int seen = 0;
            for (int k = 0; k < 3; k++) begin
                i_tvalid = 1'b1;
                i_tuser  = 1'b0;
                i_tdata  = {AW'(40 + k), FW'(0)};
                i_tlast  = 1'b1;
                tick();
            end
            i_tvalid = 1'b0;
            reset    = 1'b1;
            tick();
            chk("midreset.o_tvalid", {31'd0, o_tvalid}, 0);
            tick();
            reset = 1'b0;
            tick();
            chk("midreset.i_tready", {31'd0, i_tready}, 1);
            for (int k = 0; k < 10; k++) begin
                if (o_tvalid) seen++;
                tick();
            end
            chk("midreset.flushed", seen, 0);
            send_one(0, 5, 64, 1'b1, 88, 1'b0, "midreset.fresh");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
